// File: rtl/rally_pkg.sv
// Shared types and helpers for the rally game core.
package rally_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_RUN_R = 3'd2,
      S_RUN_L = 3'd3,
      S_POINT = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

   // max(p - dec, min_p) without ever going below zero
   function automatic int unsigned next_period(input int unsigned p,
                                               input int unsigned dec,
                                               input int unsigned min_p);
      if (p >= min_p + dec) return p - dec;
      return min_p;
   endfunction

endpackage

// File: rtl/rally_step_timer.sv
// Loadable down-counter; expire is high while enabled and the count sits at zero.
module rally_step_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (en && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/rally_core.sv
// Two-player LED rally: ball movement, returns with speed-up, scoring and match control.
module rally_core
   import rally_pkg::*;
#(
   parameter int unsigned LANE_LEN  = 8,
   parameter int unsigned SCORE_W   = 3,
   parameter int unsigned WIN_SCORE = 5,
   parameter int unsigned TICK_W    = 24,
   parameter int unsigned STEP_INIT = 12000000,
   parameter int unsigned STEP_DEC  = 1000000,
   parameter int unsigned STEP_MIN  = 3000000,
   parameter int unsigned HOLD_CYC  = 24000000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        p1,
   input  logic                        p2,
   input  logic                        kick,
   output logic [$clog2(LANE_LEN)-1:0] pos,
   output logic [LANE_LEN-1:0]         led,
   output logic [2:0]                  state,
   output logic [SCORE_W-1:0]          sc1,
   output logic [SCORE_W-1:0]          sc2,
   output logic                        win1,
   output logic                        win2,
   output logic                        err,
   output logic                        match_over,
   output logic                        winner
);

   localparam int unsigned POS_W  = $clog2(LANE_LEN);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(LANE_LEN - 1);

   if (WIN_SCORE > 2**SCORE_W - 1) begin : g_bad_win
      $error("rally_core: WIN_SCORE does not fit in SCORE_W bits");
   end
   if (LANE_LEN < 3) begin : g_bad_lane
      $error("rally_core: LANE_LEN must be at least 3");
   end

   state_t               state_q, state_d;
   player_t              server_q, server_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic [LANE_LEN-1:0]  led_q, led_d;
   logic [SCORE_W-1:0]   sc1_q, sc1_d, sc2_q, sc2_d, new_sc;
   logic [TICK_W-1:0]    period_q, period_d, period_nxt;
   logic                 win1_q, win1_d, win2_q, win2_d, err_q, err_d;
   logic                 over_q, over_d, winner_q, winner_d;

   logic                 step_load, step_exp, hold_load, hold_exp;
   logic [TICK_W-1:0]    step_val;
   logic                 rx_press, at_end, point;

   rally_step_timer #(.W(TICK_W)) u_step (
      .clk      (clk),
      .reset    (reset),
      .load     (step_load),
      .load_val (step_val),
      .en       (state_q == S_RUN_R || state_q == S_RUN_L),
      .expire   (step_exp)
   );

   rally_step_timer #(.W(HOLD_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .load_val (HOLD_W'(HOLD_CYC - 1)),
      .en       (state_q == S_POINT),
      .expire   (hold_exp)
   );

   assign period_nxt = TICK_W'(next_period(32'(period_q), STEP_DEC, STEP_MIN));

   always_comb begin
      state_d   = state_q;
      server_d  = server_q;
      pos_d     = pos_q;
      sc1_d     = sc1_q;
      sc2_d     = sc2_q;
      period_d  = period_q;
      winner_d  = winner_q;
      win1_d    = 1'b0;
      win2_d    = 1'b0;
      err_d     = 1'b0;
      step_load = 1'b0;
      step_val  = period_q - TICK_W'(1);
      hold_load = 1'b0;
      point     = 1'b0;
      new_sc    = '0;
      // the receiver is the player the ball is travelling toward
      rx_press  = (state_q == S_RUN_R) ? p2 : p1;
      at_end    = (state_q == S_RUN_R) ? (pos_q == POS_MAX) : (pos_q == '0);

      case (state_q)
         S_IDLE: begin
            if (kick) begin
               state_d  = S_SERVE;
               server_d = P1;
               pos_d    = '0;
               period_d = TICK_W'(STEP_INIT);
            end
         end
         S_SERVE: begin
            if ((server_q == P1 && p1) || (server_q == P2 && p2)) begin
               state_d   = (server_q == P1) ? S_RUN_R : S_RUN_L;
               step_load = 1'b1;
               step_val  = TICK_W'(STEP_INIT - 1);
            end
         end
         S_RUN_R, S_RUN_L: begin
            if (rx_press && at_end) begin
               state_d   = (state_q == S_RUN_R) ? S_RUN_L : S_RUN_R;
               pos_d     = (state_q == S_RUN_R) ? POS_MAX - POS_W'(1) : POS_W'(1);
               period_d  = period_nxt;
               step_load = 1'b1;
               step_val  = period_nxt - TICK_W'(1);
            end else if (rx_press) begin
               err_d = 1'b1;
               point = 1'b1;
            end else if (step_exp && at_end) begin
               point = 1'b1;
            end else if (step_exp) begin
               pos_d     = (state_q == S_RUN_R) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
               step_load = 1'b1;
            end
         end
         S_POINT: begin
            if (hold_exp) begin
               state_d  = S_SERVE;
               pos_d    = (server_q == P1) ? '0 : POS_MAX;
               period_d = TICK_W'(STEP_INIT);
            end
         end
         S_OVER: begin
            if (kick) begin
               state_d  = S_IDLE;
               server_d = P1;
               pos_d    = '0;
               sc1_d    = '0;
               sc2_d    = '0;
               winner_d = 1'b0;
               period_d = TICK_W'(STEP_INIT);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // every point is lost by the receiver, who then serves
      if (point) begin
         hold_load = 1'b1;
         if (state_q == S_RUN_R) begin
            sc1_d    = sc1_q + SCORE_W'(1);
            new_sc   = sc1_d;
            win1_d   = 1'b1;
            server_d = P2;
         end else begin
            sc2_d    = sc2_q + SCORE_W'(1);
            new_sc   = sc2_d;
            win2_d   = 1'b1;
            server_d = P1;
         end
         if (new_sc == SCORE_W'(WIN_SCORE)) begin
            state_d  = S_OVER;
            winner_d = (state_q == S_RUN_R) ? 1'b0 : 1'b1;
         end else begin
            state_d  = S_POINT;
         end
      end

      over_d = (state_d == S_OVER);
      led_d  = '0;
      if (state_d != S_IDLE && state_d != S_OVER)
         led_d[pos_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         server_q <= P1;
         pos_q    <= '0;
         led_q    <= '0;
         sc1_q    <= '0;
         sc2_q    <= '0;
         period_q <= TICK_W'(STEP_INIT);
         win1_q   <= 1'b0;
         win2_q   <= 1'b0;
         err_q    <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         server_q <= server_d;
         pos_q    <= pos_d;
         led_q    <= led_d;
         sc1_q    <= sc1_d;
         sc2_q    <= sc2_d;
         period_q <= period_d;
         win1_q   <= win1_d;
         win2_q   <= win2_d;
         err_q    <= err_d;
         over_q   <= over_d;
         winner_q <= winner_d;
      end
   end

   assign state      = state_q;
   assign pos        = pos_q;
   assign led        = led_q;
   assign sc1        = sc1_q;
   assign sc2        = sc2_q;
   assign win1       = win1_q;
   assign win2       = win2_q;
   assign err        = err_q;
   assign match_over = over_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_rally_core.sv
// Bench for rally_core: directed scenarios with literal checks plus a random phase,
// all cycles compared against a behavioural rally model.
module tb_rally_core;

   localparam int L     = 4;
   localparam int WIN   = 2;
   localparam int SINIT = 4;
   localparam int SDEC  = 1;
   localparam int SMIN  = 2;
   localparam int HOLD  = 3;

   logic       clk = 1'b0;
   logic       reset, p1, p2, kick;
   logic [1:0] pos;
   logic [3:0] led;
   logic [2:0] state;
   logic [2:0] sc1, sc2;
   logic       win1, win2, err, match_over, winner;

   rally_core #(
      .LANE_LEN(L), .SCORE_W(3), .WIN_SCORE(WIN), .TICK_W(8),
      .STEP_INIT(SINIT), .STEP_DEC(SDEC), .STEP_MIN(SMIN), .HOLD_CYC(HOLD)
   ) dut (
      .clk(clk), .reset(reset), .p1(p1), .p2(p2), .kick(kick),
      .pos(pos), .led(led), .state(state), .sc1(sc1), .sc2(sc2),
      .win1(win1), .win2(win2), .err(err), .match_over(match_over), .winner(winner)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: states 0 idle,1 serve,2 right,3 left,4 point,5 over.
   // age = cycles already spent at the current position; hold = cycles spent in point.
   int m_st = 0, m_pos = 0, m_sc1 = 0, m_sc2 = 0, m_srv = 0, m_per = SINIT;
   int m_age = 0, m_hold = 0, m_w1 = 0, m_w2 = 0, m_err = 0, m_winner = 0;
   bit mvalid = 0;

   task automatic award(input int scorer);
      int s;
      if (scorer == 0) begin m_sc1++; m_w1 = 1; s = m_sc1; end
      else             begin m_sc2++; m_w2 = 1; s = m_sc2; end
      m_srv  = 1 - scorer;
      m_hold = 0;
      if (s == WIN) begin m_st = 5; m_winner = scorer; end
      else m_st = 4;
   endtask

   task automatic model_step();
      int dir, rend, rp;
      bit expired;
      m_w1 = 0; m_w2 = 0; m_err = 0;
      if (reset) begin
         m_st = 0; m_pos = 0; m_sc1 = 0; m_sc2 = 0; m_srv = 0; m_per = SINIT;
         m_winner = 0; m_age = 0; m_hold = 0;
         return;
      end
      case (m_st)
         0: if (kick) begin m_st = 1; m_srv = 0; m_pos = 0; m_per = SINIT; end
         1: if ((m_srv == 0 && p1) || (m_srv == 1 && p2)) begin
               m_st = (m_srv == 0) ? 2 : 3; m_age = 0;
            end
         2, 3: begin
            dir  = (m_st == 2) ? 1 : -1;
            rend = (m_st == 2) ? L - 1 : 0;
            rp   = (m_st == 2) ? int'(p2) : int'(p1);
            expired = (m_age == m_per - 1);
            if (rp != 0 && m_pos == rend) begin
               m_st  = 5 - m_st;
               m_pos = m_pos - dir;
               m_per = (m_per - SDEC > SMIN) ? m_per - SDEC : SMIN;
               m_age = 0;
            end else if (rp != 0) begin
               m_err = 1;
               award(m_st == 2 ? 0 : 1);
            end else if (expired && m_pos == rend) begin
               award(m_st == 2 ? 0 : 1);
            end else if (expired) begin
               m_pos = m_pos + dir; m_age = 0;
            end else m_age++;
         end
         4: if (m_hold == HOLD - 1) begin
               m_st = 1; m_pos = (m_srv == 0) ? 0 : L - 1; m_per = SINIT;
            end else m_hold++;
         5: if (kick) begin
               m_st = 0; m_sc1 = 0; m_sc2 = 0; m_srv = 0; m_pos = 0; m_winner = 0;
            end
         default: ;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      mvalid = 1;
   end

   // one compare process, every cycle once the model has seen its first edge
   initial forever begin
      @(negedge clk);
      if (mvalid) begin
         chk("m.state", int'(state), m_st);
         chk("m.pos", int'(pos), m_pos);
         chk("m.led", int'(led), (m_st == 0 || m_st == 5) ? 0 : (1 << m_pos));
         chk("m.sc1", int'(sc1), m_sc1);
         chk("m.sc2", int'(sc2), m_sc2);
         chk("m.win1", int'(win1), m_w1);
         chk("m.win2", int'(win2), m_w2);
         chk("m.err", int'(err), m_err);
         chk("m.over", int'(match_over), (m_st == 5) ? 1 : 0);
         chk("m.winner", int'(winner), m_winner);
      end
   end

   task automatic step(input logic a, input logic b, input logic k);
      p1 = a; p2 = b; kick = k;
      @(negedge clk);
      p1 = 1'b0; p2 = 1'b0; kick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic a, b, k;
      reset = 1'b1; p1 = 1'b0; p2 = 1'b0; kick = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst.state", int'(state), 0);
      chk("rst.pos", int'(pos), 0);
      chk("rst.led", int'(led), 0);
      chk("rst.scores", int'(sc1) + int'(sc2), 0);
      chk("rst.over", int'(match_over), 0);
      reset = 1'b0;

      // 1: serve, walk the lane, p2 misses
      step(0, 0, 1);          chk("t1.serve", int'(state), 1);
      step(1, 0, 0);          chk("t1.run", int'(state), 2);
      idle(3);                chk("t1.pos0", int'(pos), 0);
      idle(1);                chk("t1.pos1", int'(pos), 1);
      idle(8);                chk("t1.pos3", int'(pos), 3);
      idle(3);                chk("t1.still", int'(state), 2);
      idle(1);                chk("t1.point", int'(state), 4);
      chk("t1.win1", int'(win1), 1);
      chk("t1.sc1", int'(sc1), 1);
      chk("t1.led", int'(led), 8);
      idle(2);                chk("t1.hold", int'(state), 4);
      idle(1);                chk("t1.serve2", int'(state), 1);
      chk("t1.srvpos", int'(pos), 3);

      // 2: returns at each end, periods 4,3,2,2
      step(0, 1, 0);          chk("t2.runl", int'(state), 3);
      idle(4);                chk("t2.pos2", int'(pos), 2);
      idle(8);                chk("t2.pos0", int'(pos), 0);
      step(1, 0, 0);          chk("t2.ret1", int'(pos), 1);
      idle(2);                chk("t2.p3a", int'(pos), 1);
      idle(1);                chk("t2.p3b", int'(pos), 2);
      idle(3);                chk("t2.end", int'(pos), 3);
      step(0, 1, 0);          chk("t2.ret2", int'(pos), 2);
      idle(1);                chk("t2.p2a", int'(pos), 2);
      idle(1);                chk("t2.p2b", int'(pos), 1);
      idle(2);                step(1, 0, 0);
      chk("t2.ret3", int'(state), 2);
      idle(1);                chk("t2.sata", int'(pos), 1);
      idle(1);                chk("t2.satb", int'(pos), 2);

      // 3: early p2 press is a foul; second p1 point ends the match
      step(0, 1, 0);
      chk("t3.err", int'(err), 1);
      chk("t3.win1", int'(win1), 1);
      chk("t3.sc1", int'(sc1), 2);
      chk("t3.over", int'(match_over), 1);
      chk("t3.winner", int'(winner), 0);
      step(0, 0, 1);          chk("t3.idle", int'(state), 0);
      chk("t3.clr", int'(sc1), 0);

      // 4: press on the exact expiry cycle is a return
      step(0, 0, 1); step(1, 0, 0);
      idle(12);               chk("t4.pos3", int'(pos), 3);
      idle(3);  step(0, 1, 0);
      chk("t4.dir", int'(state), 3);
      chk("t4.nowin", int'(win1), 0);

      // 5: simultaneous presses at the right end, then p1 wins the match
      idle(3);  idle(3);      chk("t5.pos0", int'(pos), 0);
      step(1, 0, 0);          chk("t5.ret", int'(state), 2);
      idle(4);                chk("t5.pos3", int'(pos), 3);
      step(1, 1, 0);          chk("t5.both", int'(state), 3);
      chk("t5.noerr", int'(err), 0);
      idle(4);  step(1, 0, 0);
      idle(6);                chk("t5.miss", int'(sc1), 1);
      idle(3);                chk("t5.p2srv", int'(pos), 3);
      step(0, 1, 0);  idle(12);
      step(1, 0, 0);  step(0, 1, 0);
      chk("t5.over", int'(match_over), 1);
      chk("t5.winner", int'(winner), 0);
      step(0, 0, 1);          chk("t5.idle", int'(sc1) + int'(sc2) + int'(state), 0);

      // 6: reset during a rally
      step(0, 0, 1); step(1, 0, 0); step(0, 1, 0);
      idle(3);  step(0, 1, 0);
      idle(8);                chk("t6.pre", int'(pos), 1);
      chk("t6.prest", int'(state), 3);
      reset = 1'b1; step(0, 0, 0); reset = 1'b0;
      chk("t6.state", int'(state), 0);
      chk("t6.sc1", int'(sc1), 0);
      step(1, 0, 0);          chk("t6.ign", int'(state), 0);

      // random phase, driver steered by the model's view of the game
      for (int i = 0; i < 5000; i++) begin
         a = 1'b0; b = 1'b0; k = 1'b0;
         case (m_st)
            0, 5: k = ($urandom_range(0, 3) == 0);
            1: begin
               a = ($urandom_range(0, 2) == 0);
               b = ($urandom_range(0, 2) == 0);
            end
            2, 3: begin
               if ((m_st == 2 && m_pos == L - 1) || (m_st == 3 && m_pos == 0)) begin
                  if ($urandom_range(0, 9) < 4) begin
                     if (m_st == 2) b = 1'b1; else a = 1'b1;
                  end
               end
               if ($urandom_range(0, 39) == 0) a = 1'b1;
               if ($urandom_range(0, 39) == 0) b = 1'b1;
               k = ($urandom_range(0, 19) == 0);
            end
            default: begin
               a = ($urandom_range(0, 4) == 0);
               b = ($urandom_range(0, 4) == 0);
               k = ($urandom_range(0, 9) == 0);
            end
         endcase
         reset = ($urandom_range(0, 799) == 0);
         step(a, b, k);
      end
      reset = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
